shift_add_multiplier_16bit: RTL and testbench

Sequential 16x16 unsigned multiplier that drives the team's `carry_look_ahead_16bit` adder. Each cycle it feeds the running partial-product high half and the multiplicand into one `carry_look_ahead_16bit` instance, and consumes that adder's sum and carry-out. A start/done handshake yields a 32-bit product 17 cycles after start. It is the first multi-cycle arithmetic unit built on the CLA datapath.

---
 rtl/shift_add_multiplier_16bit_if.sv | 12 +
 rtl/shift_add_multiplier_16bit.sv | 130 +++++++++++++
 tb/tb_shift_add_multiplier_16bit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_16bit_if.sv
// Start/done handshake and operand/product bus for the 16x16 shift-add multiplier.
interface shift_add_multiplier_16bit_if;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [31:0] P;

  modport master (output start, A, B, input busy, done, P);
  modport slave  (input start, A, B, output busy, done, P);
endinterface

// File: rtl/shift_add_multiplier_16bit.sv
// Sequential 16x16 unsigned multiplier: one CLA add + right shift per cycle, 16 iterations.
module carry_look_ahead_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_co,
  output logic        o_pg,
  output logic        o_gg
);
  logic [15:0] w_p, w_g;
  logic [16:0] w_c;
  logic [3:0]  w_gp, w_gg;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Group carries come from 4-bit lookahead terms; bit carries ripple inside a group.
  always_comb begin
    w_c    = '0;
    w_gp   = '0;
    w_gg   = '0;
    w_c[0] = i_cin;
    for (int k = 0; k < 4; k++) begin
      w_gp[k] = &w_p[4*k +: 4];
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      for (int j = 0; j < 3; j++)
        w_c[4*k+j+1] = w_g[4*k+j] | (w_p[4*k+j] & w_c[4*k+j]);
      w_c[4*k+4] = w_gg[k] | (w_gp[k] & w_c[4*k]);
    end
  end

  assign o_sum = w_p ^ w_c[15:0];
  assign o_co  = w_c[16];
  assign o_pg  = &w_gp;
  assign o_gg  = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
               | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
endmodule

module shift_add_multiplier_16bit (
  input  logic                         clk,
  input  logic                         rst_n,
  shift_add_multiplier_16bit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      r_state, w_next;
  logic [15:0] r_m, r_hi, r_lo;
  logic [3:0]  r_cnt;
  logic [31:0] r_p;
  logic        w_load, w_step, w_finish;
  logic [15:0] w_sum, w_s, w_hi_nx, w_lo_nx;
  logic        w_co, w_c;

  carry_look_ahead_16bit u_cla (
    .i_a   (r_hi),
    .i_b   (r_m),
    .i_cin (1'b0),
    .o_sum (w_sum),
    .o_co  (w_co),
    .o_pg  (),
    .o_gg  ()
  );

  // Carry-out lands in hi[15] after the shift, so the full 17-bit sum is kept.
  assign {w_c, w_s} = r_lo[0] ? {w_co, w_sum} : {1'b0, r_hi};
  assign w_hi_nx    = {w_c, w_s[15:1]};
  assign w_lo_nx    = {w_s[0], r_lo[15:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      IDLE: if (bus.start) begin
        w_next = RUN;
        w_load = 1'b1;
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == 4'd15) begin
          w_next   = DONE;
          w_finish = 1'b1;
        end
      end
      DONE: begin
        if (bus.start) begin
          w_next = RUN;
          w_load = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else if (w_load) begin
      r_m   <= bus.A;
      r_hi  <= '0;
      r_lo  <= bus.B;
      r_cnt <= '0;
    end else if (w_step) begin
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      r_cnt <= r_cnt + 4'd1;
      if (w_finish) r_p <= {w_hi_nx, w_lo_nx};
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.P    = r_p;
endmodule

// File: tb/tb_shift_add_multiplier_16bit.sv
// Scoreboard bench: products pushed on start, popped and compared at done.
module tb_shift_add_multiplier_16bit;
  logic clk;
  logic rst_n;
  shift_add_multiplier_16bit_if bus ();

  shift_add_multiplier_16bit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Starts one op at the current negedge and returns at the negedge where done is seen.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input string tag,
                       input int poke, input bit hold);
    int cyc, nb;
    logic [31:0] e;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    sb.push_back({16'h0, a} * {16'h0, b});
    tick();
    cyc = 1;
    nb  = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) nb++;
      bus.start = hold || (cyc == poke);
      if (cyc == poke) begin
        bus.A = 16'h0009;
        bus.B = 16'h0009;
      end else if (!hold) begin
        bus.A = 16'($urandom);
        bus.B = 16'($urandom);
      end
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'd17);
    chk({tag, "_busycnt"}, 32'(nb), 32'd16);
    chk({tag, "_busy_at_done"}, {31'h0, bus.busy}, 32'h0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_P"}, bus.P, e);
    end else begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end
  endtask

  task automatic finish_op(input string tag);
    bus.start = 1'b0;
    tick();
    chk({tag, "_done_pulse"}, {31'h0, bus.done}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    tick();
    tick();
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_P", bus.P, 32'h0);
    rst_n = 1'b1;
    tick();

    do_op(16'h0003, 16'h0005, "basic", -1, 1'b0);
    finish_op("basic");
    repeat (4) tick();
    chk("basic_hold_P", bus.P, 32'h0000000F);

    do_op(16'hFFFF, 16'hFFFF, "max", -1, 1'b0);
    finish_op("max");
    chk("max_const", bus.P, 32'hFFFE0001);
    do_op(16'h1234, 16'h0000, "zero", -1, 1'b0);
    finish_op("zero");
    do_op(16'hAB1D, 16'h5B5B, "rnd1", -1, 1'b0);
    finish_op("rnd1");
    do_op(16'h1F1F, 16'h7A7A, "rnd2", -1, 1'b0);
    finish_op("rnd2");
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op(ra, rb, "urand", -1, 1'b0);
      finish_op("urand");
    end

    do_op(16'h0002, 16'h0002, "poke", 5, 1'b0);
    finish_op("poke");
    chk("poke_P", bus.P, 32'h00000004);

    // Abort an operation with reset; no result is expected from it.
    bus.start = 1'b1;
    bus.A     = 16'h00FF;
    bus.B     = 16'h00FF;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    chk("abort_busy_before", {31'h0, bus.busy}, 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", {31'h0, bus.busy}, 32'h0);
    chk("abort_done", {31'h0, bus.done}, 32'h0);
    chk("abort_P", bus.P, 32'h0);
    tick();
    do_op(16'h0002, 16'h0003, "after_rst", -1, 1'b0);
    finish_op("after_rst");
    chk("after_rst_const", bus.P, 32'h00000006);

    do_op(16'h0010, 16'h0010, "b2b1", -1, 1'b1);
    do_op(16'h0100, 16'h0100, "b2b2", -1, 1'b0);
    finish_op("b2b2");
    chk("b2b2_const", bus.P, 32'h00010000);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
